// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_ACK
    } arb_state_t;

    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    // Ceiling log2 with a floor of one bit so single-bit indices stay legal.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx byte-interface bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WORD_BYTES = 4
);
    localparam int unsigned W = 8 * WORD_BYTES;

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*W-1:0] data;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_active;
    logic                 tx_done;

    modport master (
        output req, data, tx_active, tx_done,
        input  grant, done, busy, tx_dv, tx_byte
    );

    modport slave (
        input  req, data, tx_active, tx_done,
        output grant, done, busy, tx_dv, tx_byte
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after the last owner.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_valid_c,
    output logic [IDX_W-1:0]   o_idx_c,
    output logic [NUM_REQ-1:0] o_onehot_c
);

    int unsigned w_cand;

    // Scan from the farthest candidate inward so the nearest hit wins.
    always_comb begin
        o_valid_c  = 1'b0;
        o_idx_c    = '0;
        o_onehot_c = '0;
        w_cand     = 0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            w_cand = (32'(i_last) + k) % NUM_REQ;
            if (i_req[IDX_W'(w_cand)]) begin
                o_valid_c  = 1'b1;
                o_idx_c    = IDX_W'(w_cand);
                o_onehot_c = NUM_REQ'(1) << w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between word-wide requesters, MSB byte first.
// Define UART_ARB_ID_HEADER_EN to prefix each transfer with {4'hA, owner_id}.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WORD_BYTES = 4
) (
    input logic         clk,
    input logic         reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned W     = 8 * WORD_BYTES;
    localparam int unsigned IDX_W = clog2(NUM_REQ);
`ifdef UART_ARB_ID_HEADER_EN
    localparam int unsigned NBYTES = WORD_BYTES + 1;
`else
    localparam int unsigned NBYTES = WORD_BYTES;
`endif
    localparam int unsigned SW    = 8 * NBYTES;
    localparam int unsigned CNT_W = clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;
    logic               r_tx_dv;
    logic [7:0]         r_tx_byte;
    logic [CNT_W-1:0]   r_cnt;
    logic [SW-1:0]      r_shift;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_owner;

    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_onehot;
    logic [W-1:0]       w_word;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req      (bus.req),
        .i_last     (r_last),
        .o_valid_c  (w_valid),
        .o_idx_c    (w_idx),
        .o_onehot_c (w_onehot)
    );

    // Word of the requester the picker selected.
    always_comb begin
        w_word = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_idx == IDX_W'(i)) w_word = bus.data[i*W +: W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_done    <= '0;
            r_busy    <= 1'b0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_last    <= IDX_W'(NUM_REQ - 1);
            r_owner   <= '0;
        end else begin
            r_tx_dv <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_grant <= w_onehot;
                        r_owner <= w_idx;
`ifdef UART_ARB_ID_HEADER_EN
                        r_shift <= {HDR_NIBBLE, 4'(w_idx), w_word};
`else
                        r_shift <= w_word;
`endif
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (!bus.tx_active) begin
                        r_tx_dv   <= 1'b1;
                        r_tx_byte <= r_shift[SW-1 -: 8];
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.tx_done) begin
                        r_shift <= {r_shift[SW-9:0], 8'h00};
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_CNT) begin
                            r_done  <= r_grant;
                            r_state <= S_ACK;
                        end else begin
                            r_state <= S_SEND;
                        end
                    end
                end
                S_ACK: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant   = r_grant;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;
    assign bus.tx_dv   = r_tx_dv;
    assign bus.tx_byte = r_tx_byte;

endmodule
